// File: rtl/alu19_pkg.sv
// Shared definitions for the 19-bit processor: op codes, FSM states and instruction field positions.
package alu19_pkg;

  localparam int ALU19_DATA_W = 19;
  localparam int ALU19_REG_AW = 3;
  localparam int ALU19_OP_W   = 4;

  localparam int OP_LSB  = 15;
  localparam int RD_LSB  = 12;
  localparam int RS1_LSB = 9;
  localparam int RS2_LSB = 6;
  localparam int IMM_W   = 12;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;
  localparam logic [3:0] OP_LDI = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB
  } state_t;

endpackage

// File: rtl/alu19_regfile.sv
// 2**REG_AW x DATA_W register file: two read ports, one write port, one debug read port,
// synchronous clear while rst_n is low (clear wins over a same-edge write).
module alu19_regfile #(
  parameter int DATA_W = 19,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] rf [2**REG_AW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf <= '{default: '0};
    end else if (we) begin
      rf[wa] <= wd;
    end
  end

  assign rd1      = rf[ra1];
  assign rd2      = rf[ra2];
  assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu19_issue_ctrl.sv
// Decode/issue controller for the 19-bit ALU: IDLE -> READ -> EXEC -> WB, one instruction per 4 cycles.
// Optional `ALU19_DIV0_TRAP_EN: DIV by zero suppresses writeback and raises err.
module alu19_issue_ctrl
  import alu19_pkg::*;
#(
  parameter int DATA_W = ALU19_DATA_W,
  parameter int REG_AW = ALU19_REG_AW,
  parameter int OP_W   = ALU19_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              done,
  output logic              err,
  output logic              zero_flag,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] result_q;
  logic              trap_q;

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rd_a, rs1_a, rs2_a;
  logic [DATA_W-1:0] rs1_d, rs2_d, wb_val;
  logic              illegal, is_ldi, we;
  logic              unused_alu_zero;

  assign unused_alu_zero = alu_zero;

  always_comb begin
    op      = instr_q[OP_LSB +: OP_W];
    rd_a    = instr_q[RD_LSB +: REG_AW];
    rs1_a   = instr_q[RS1_LSB +: REG_AW];
    rs2_a   = instr_q[RS2_LSB +: REG_AW];
    illegal = (op > OP_LDI);
    is_ldi  = (op == OP_LDI);
    wb_val  = is_ldi ? DATA_W'(instr_q[IMM_W-1:0]) : result_q;
    we      = (state == ST_WB) && !illegal && !trap_q;
  end

  assign instr_ready = (state == ST_IDLE);

  alu19_regfile #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (rs1_a),
    .rd1      (rs1_d),
    .ra2      (rs2_a),
    .rd2      (rs2_d),
    .we       (we),
    .wa       (rd_a),
    .wd       (wb_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      instr_q   <= '0;
      result_q  <= '0;
      trap_q    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          alu_a  <= rs1_d;
          alu_b  <= rs2_d;
          alu_op <= op;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          result_q <= alu_result;
`ifdef ALU19_DIV0_TRAP_EN
          trap_q   <= (op == OP_DIV) && (alu_b == '0);
`else
          trap_q   <= 1'b0;
`endif
          state    <= ST_WB;
        end
        ST_WB: begin
          // done/err land on the same edge as the register write, so they appear 3 cycles after accept
          done <= 1'b1;
          err  <= illegal || trap_q;
          if (!illegal && !trap_q) begin
            zero_flag <= (wb_val == '0);
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
